// File: rtl/bus_rr_matrix_if.sv
// Shared-bus signal bundle between masters, the round-robin matrix and slaves.
// slave: the matrix itself (serves the masters); master: the agents around it.
interface bus_rr_matrix_if #(
    parameter int NUM_M  = 4,
    parameter int NUM_S  = 8,
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic [NUM_M-1:0]        m_req;
    logic [NUM_M*ADDR_W-1:0] m_addr;
    logic [NUM_M-1:0]        m_as;
    logic [NUM_M-1:0]        m_rw;
    logic [NUM_M*DATA_W-1:0] m_wr_data;
    logic [NUM_M-1:0]        m_grnt;
    logic [ADDR_W-1:0]       s_addr;
    logic                    s_as;
    logic                    s_rw;
    logic [DATA_W-1:0]       s_wr_data;
    logic [NUM_S-1:0]        s_cs;
    logic [NUM_S*DATA_W-1:0] s_rd_data;
    logic [NUM_S-1:0]        s_rdy;
    logic [DATA_W-1:0]       bus_rd_data;
    logic                    bus_rdy;
    logic                    bus_err;

    modport slave (
        input  m_req, m_addr, m_as, m_rw, m_wr_data, s_rd_data, s_rdy,
        output m_grnt, s_addr, s_as, s_rw, s_wr_data, s_cs, bus_rd_data, bus_rdy, bus_err
    );

    modport master (
        output m_req, m_addr, m_as, m_rw, m_wr_data, s_rd_data, s_rdy,
        input  m_grnt, s_addr, s_as, s_rw, s_wr_data, s_cs, bus_rd_data, bus_rdy, bus_err
    );
endinterface

// File: rtl/bus_rr_matrix.sv
// NUM_M x NUM_S shared bus: registered round-robin arbiter with ownership hold,
// address decode, unmapped-address error and slave-ready timeout.
module bus_rr_matrix #(
    parameter int NUM_M   = 4,
    parameter int NUM_S   = 8,
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rest,
    bus_rr_matrix_if.slave bus
);
    localparam int OW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    typedef enum logic {IDLE, OWN} state_t;

    state_t            state;
    logic [NUM_M-1:0]  grnt;
    logic [OW-1:0]     ptr;
    logic [15:0]       wait_cnt;
    logic              err_pend;

    logic [2*NUM_M-1:0] req2;
    logic [OW:0]        sum;
    logic [OW-1:0]      pick, nxt_ptr;
    logic               pick_vld, owner_keep, do_grant, go_idle, own_chg;

    logic [ADDR_W-1:0]  addr;
    logic               as, rw;
    logic [DATA_W-1:0]  wr_data;
    logic [SEL_W-1:0]   sel;
    logic               mapped, tracking, timeout;
    logic [NUM_S-1:0]   cs;
    logic [DATA_W-1:0]  sdat;
    logic               srdy, err;

    // Rotate requests so the scan always starts at the round-robin pointer.
    always_comb begin
        req2     = {bus.m_req, bus.m_req} >> ptr;
        pick     = '0;
        pick_vld = 1'b0;
        sum      = '0;
        for (int k = 0; k < NUM_M; k++) begin
            if (!pick_vld && req2[k]) begin
                pick_vld = 1'b1;
                sum      = {1'b0, ptr} + (OW+1)'(k);
                if (sum >= (OW+1)'(NUM_M))
                    sum = sum - (OW+1)'(NUM_M);
                pick = sum[OW-1:0];
            end
        end
    end

    assign nxt_ptr    = (pick == OW'(NUM_M-1)) ? '0 : pick + 1'b1;
    assign owner_keep = |(bus.m_req & grnt);
    assign do_grant   = pick_vld && (state == IDLE || !owner_keep);
    assign go_idle    = (state == OWN) && !owner_keep && !pick_vld;
    assign own_chg    = do_grant || go_idle;

    always_comb begin
        addr    = '0;
        as      = 1'b0;
        rw      = 1'b0;
        wr_data = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (grnt[i]) begin
                addr    = bus.m_addr[i*ADDR_W +: ADDR_W];
                as      = bus.m_as[i];
                rw      = bus.m_rw[i];
                wr_data = bus.m_wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign sel    = addr[ADDR_W-1 -: SEL_W];
    assign mapped = (state == OWN) && ({1'b0, sel} < (SEL_W+1)'(NUM_S));

    always_comb begin
        cs   = '0;
        sdat = '0;
        srdy = 1'b0;
        for (int j = 0; j < NUM_S; j++) begin
            cs[j] = mapped && (sel == SEL_W'(j));
            if (cs[j]) begin
                sdat = bus.s_rd_data[j*DATA_W +: DATA_W];
                srdy = bus.s_rdy[j];
            end
        end
    end

    // A slave answering in the timeout cycle wins over the error.
    assign tracking = as && mapped;
    assign timeout  = tracking && !srdy && (wait_cnt == 16'(TIMEOUT));
    assign err      = (err_pend || timeout) && !srdy;

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state    <= IDLE;
            grnt     <= '0;
            ptr      <= '0;
            wait_cnt <= '0;
            err_pend <= 1'b0;
        end else begin
            if (do_grant) begin
                state <= OWN;
                grnt  <= {{(NUM_M-1){1'b0}}, 1'b1} << pick;
                ptr   <= nxt_ptr;
            end else if (go_idle) begin
                state <= IDLE;
                grnt  <= '0;
            end
            err_pend <= !own_chg && !err_pend && as && (state == OWN) && !mapped;
            if (own_chg || !tracking || srdy || timeout)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign bus.m_grnt      = grnt;
    assign bus.s_addr      = addr;
    assign bus.s_as        = as;
    assign bus.s_rw        = rw;
    assign bus.s_wr_data   = wr_data;
    assign bus.s_cs        = cs;
    assign bus.bus_rdy     = srdy || err_pend || timeout;
    assign bus.bus_err     = err;
    assign bus.bus_rd_data = err ? '0 : sdat;
endmodule
